ahb_slave_mem: RTL and testbench

//  AHB-Lite responder: memory-backed slave answering the transfers issued by the team's AHB master.
//  - Captures the address/control phase and completes the following data phase.
//  - Commits writes and returns read data.
//  - Signals ERROR for unmapped, misaligned or oversized transfers.
//  - Sits on the AHB side as the target for master single, INCR and WRAP read/write tasks.

---
 rtl/ahb_slave_mem.sv | 90 +++++++++
 tb/tb_ahb_slave_mem.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite memory-backed slave with OKAY/ERROR responses.
// Define WAIT_STATE_EN to insert WAIT_CYCLES wait states in every data phase.
module ahb_slave_mem #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int MEM_DEPTH = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [2:0]  Hsize,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Hrdata
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int WW = AW > 2 ? AW - 2 : 1;
  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] off_q, off_d;
  logic [1:0] size_q, size_d;
  logic write_q, write_d, rdy_q, rdy_d, err_q, err_d;
  logic acc, legal, fin;
  logic [31:0] offs, lane_mask;
  logic [3:0] be;
  logic [WW-1:0] widx;
  logic [31:0] mem [MEM_DEPTH/4];
`ifdef WAIT_STATE_EN
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  // The data phase completes only once the counter reaches WAIT_CYCLES.
  assign fin = state_q == DATA && cnt_q == CW'(WAIT_CYCLES);
  assign cnt_d = state_d == DATA && state_q == DATA && !fin ? cnt_q + 1'b1 : '0;
  assign rdy_d = state_d != ERR1 && (state_d != DATA || cnt_d == CW'(WAIT_CYCLES));
`else
  assign fin = state_q == DATA;
  assign rdy_d = state_d != ERR1;
`endif
  always_comb begin
    offs = Haddr - ADDR_BASE;
    acc = Hreadyin && rdy_q && Htrans inside {2'b10, 2'b11};
    legal = offs < 32'(MEM_DEPTH) && !Hsize[2] && Hsize[1:0] != 2'b11 &&
            !(Hsize[1:0] == 2'b01 && Haddr[0]) && !(Hsize[1:0] == 2'b10 && Haddr[1:0] != 2'b00);
    state_d = state_q == ERR1 ? ERR2 :
              (state_q == DATA && !fin) ? DATA :
              !acc ? IDLE : legal ? DATA : ERR1;
    err_d = state_d == ERR1 || state_d == ERR2;
    off_d = acc ? offs[AW-1:0] : off_q;
    size_d = acc ? Hsize[1:0] : size_q;
    write_d = acc ? Hwrite : write_q;
    be = size_q == 2'd0 ? 4'b0001 << off_q[1:0] :
         size_q == 2'd1 ? (off_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    widx = WW'(off_q >> 2);
    Hrdata = fin && !write_q ? mem[widx] & lane_mask : '0;
  end
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q <= IDLE;
      rdy_q <= 1'b1;
      err_q <= 1'b0;
      write_q <= 1'b0;
      size_q <= '0;
      off_q <= '0;
`ifdef WAIT_STATE_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rdy_q <= rdy_d;
      err_q <= err_d;
      write_q <= write_d;
      size_q <= size_d;
      off_q <= off_d;
`ifdef WAIT_STATE_EN
      cnt_q <= cnt_d;
`endif
    end
  end
  // Contents survive reset; a write still in flight when reset hits is dropped.
  always_ff @(posedge Hclk)
    if (fin && write_q && !Hreset)
      mem[widx] <= (mem[widx] & ~lane_mask) | (Hwdata & lane_mask);
  assign Hreadyout = rdy_q;
  assign Hresp = {1'b0, err_q};
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: scoreboard bench for ahb_slave_mem; stimulus queues expected data-phase
// responses, a bus monitor pops and compares them as each data phase completes.
module tb_ahb_slave_mem;
  logic Hclk = 0, Hreset = 1, Hwrite = 0, Hreadyin = 1;
  logic [1:0] Htrans = 0;
  logic [2:0] Hsize = 0;
  logic [31:0] Haddr = 0, Hwdata = 0;
  logic Hreadyout;
  logic [1:0] Hresp;
  logic [31:0] Hrdata;
  int checks = 0, errors = 0;
`ifdef WAIT_STATE_EN
  localparam int WC = 2;
`else
  localparam int WC = 0;
`endif
  typedef struct { string name; logic [1:0] resp; logic [31:0] rdata; int waits; } exp_t;
  exp_t q[$];
  logic in_phase = 0;
  int waits = 0;
  logic [31:0] pend_wd = 0;

  ahb_slave_mem #(.WAIT_CYCLES(2)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans),
    .Hsize(Hsize), .Haddr(Haddr), .Hwdata(Hwdata), .Hreadyout(Hreadyout), .Hresp(Hresp),
    .Hrdata(Hrdata)
  );

  always #5 Hclk = ~Hclk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Track whether a data phase is in progress from the bus handshake itself.
  always @(posedge Hclk) begin
    if (Hreset) begin
      in_phase = 0;
      waits = 0;
    end else begin
      if (in_phase && Hreadyout) begin
        in_phase = 0;
        waits = 0;
      end
      if (Hreadyin && Hreadyout && Htrans[1]) in_phase = 1;
    end
  end

  always @(negedge Hclk) begin
    exp_t e;
    if (!Hreset) begin
      if (!in_phase) begin
        chk("idle_ready", 32'(Hreadyout), 32'd1);
        chk("idle_resp", 32'(Hresp), 32'd0);
        chk("idle_rdata", Hrdata, 32'd0);
      end else if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_phase: got data phase expected none");
      end else if (!Hreadyout) begin
        waits++;
        chk($sformatf("%s_wait_resp", q[0].name), 32'(Hresp), 32'(q[0].resp));
      end else begin
        e = q.pop_front();
        chk($sformatf("%s_resp", e.name), 32'(Hresp), 32'(e.resp));
        chk($sformatf("%s_rdata", e.name), Hrdata, e.rdata);
        chk($sformatf("%s_waits", e.name), 32'(waits), 32'(e.waits));
      end
    end
  end

  task automatic beat(input logic [1:0] tr, input logic w, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, input logic [1:0] er,
                      input logic [31:0] ed, input int ew, input string nm);
    logic rdy;
    exp_t e;
    Htrans = tr; Hwrite = w; Hsize = sz; Haddr = a; Hwdata = pend_wd;
    rdy = 0;
    for (int i = 0; i < 20 && !rdy; i++) begin
      @(negedge Hclk);
      rdy = Hreadyout;
      @(posedge Hclk);
      #1;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got no ready expected ready within 20 cycles", nm);
    end else if (tr[1]) begin
      e.name = nm; e.resp = er; e.rdata = ed; e.waits = ew;
      q.push_back(e);
    end
    pend_wd = wd;
  endtask

  task automatic wr(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd, input string nm);
    beat(2'b10, 1'b1, sz, a, wd, 2'b00, 32'h0, WC, nm);
  endtask
  task automatic rd(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] ed, input string nm);
    beat(2'b10, 1'b0, sz, a, 32'h0, 2'b00, ed, WC, nm);
  endtask
  task automatic bad(input logic w, input logic [2:0] sz, input logic [31:0] a, input string nm);
    beat(2'b10, w, sz, a, 32'hDEAD_BEEF, 2'b01, 32'h0, 1, nm);
  endtask
  task automatic idle();
    beat(2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 2'b00, 32'h0, 0, "idle");
  endtask

  initial begin
    repeat (3) @(posedge Hclk);
    #1 Hreset = 0;
    wr(3'b000, 32'h8000_0001, 32'h0000_A300, "byte_wr");
    rd(3'b000, 32'h8000_0001, 32'h0000_A300, "byte_rd");
    idle();
    for (int i = 0; i < 4; i++)
      beat(i == 0 ? 2'b10 : 2'b11, 1'b1, 3'b010, 32'h8000_0010 + 32'(4 * i),
           32'h1111_1111 * 32'(i + 1), 2'b00, 32'h0, WC, "incr_wr");
    rd(3'b010, 32'h8000_001C, 32'h4444_4444, "raw_rd");
    for (int i = 0; i < 4; i++)
      beat(i == 0 ? 2'b10 : 2'b11, 1'b0, 3'b010, 32'h8000_0010 + 32'(4 * i), 32'h0,
           2'b00, 32'h1111_1111 * 32'(i + 1), WC, "incr_rd");
    wr(3'b010, 32'h8000_0000, 32'h0BAD_F00D, "pre_wr");
    bad(1'b1, 3'b010, 32'h9000_0000, "unmapped_wr");
    rd(3'b010, 32'h8000_0000, 32'h0BAD_F00D, "unchanged_rd");
    idle();
    bad(1'b0, 3'b010, 32'h8000_0002, "misalign_word");
    bad(1'b0, 3'b001, 32'h8000_0003, "misalign_half");
    bad(1'b0, 3'b011, 32'h8000_0020, "oversize");
    bad(1'b0, 3'b010, 32'h7FFF_FFFC, "below_base");
    bad(1'b0, 3'b000, 32'h8000_0100, "above_top");
    wr(3'b000, 32'h8000_00FF, 32'h7700_0000, "top_wr");
    rd(3'b000, 32'h8000_00FF, 32'h7700_0000, "top_rd");
    rd(3'b001, 32'h8000_0012, 32'h1111_0000, "half_rd");
    wr(3'b001, 32'h8000_0016, 32'hABCD_0000, "half_wr");
    rd(3'b010, 32'h8000_0014, 32'hABCD_2222, "merge_rd");
    rd(3'b000, 32'h8000_001F, 32'h4400_0000, "lane3_rd");
    idle();
    Hreadyin = 0; Htrans = 2'b10; Hwrite = 0; Hsize = 3'b010; Haddr = 32'h8000_0010;
    @(posedge Hclk);
    #1 Hreadyin = 1; Htrans = 2'b00;
    @(posedge Hclk);
    #1;
`ifdef WAIT_STATE_EN
    wr(3'b010, 32'h8000_0040, 32'h5A5A_1234, "wait_wr");
    rd(3'b010, 32'h8000_0040, 32'h5A5A_1234, "wait_rd");
    idle();
    wr(3'b000, 32'h8000_0041, 32'h0000_FF00, "rst_wr");
    Htrans = 2'b00; Hwdata = pend_wd;
    @(posedge Hclk);
    #1 Hreset = 1;
    q.delete();
    pend_wd = 0;
    @(posedge Hclk);
    #1 Hreset = 0;
    rd(3'b000, 32'h8000_0041, 32'h0000_1200, "rst_readback");
    idle();
`endif
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge Hclk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
